// File: rtl/axi_slave_read_ctrl.sv
// AXI read-channel slave fronting a single-port 32-bit SRAM.
// One burst outstanding; each beat is one SRAM fetch cycle plus one response cycle.
module axi_slave_read_ctrl #(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [7:0]               ARID_S,
  input  logic [31:0]              ARADDR_S,
  input  logic [3:0]               ARLEN_S,
  input  logic [2:0]               ARSIZE_S,
  input  logic [1:0]               ARBURST_S,
  input  logic                     ARVALID_S,
  output logic                     ARREADY_S,
  output logic [7:0]               RID_S,
  output logic [31:0]              RDATA_S,
  output logic [1:0]               RRESP_S,
  output logic                     RLAST_S,
  output logic                     RVALID_S,
  input  logic                     RREADY_S,
  output logic                     MEM_CS,
  output logic                     MEM_OE,
  output logic [MEM_ADDR_BITS-1:0] MEM_A,
  input  logic [31:0]              MEM_DO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                   state_q;
  logic [3:0]               beat_q;
  logic [3:0]               len_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [7:0]               id_q;
  logic                     err_q;
  logic [31:0]              data_q;
  logic                     arready_q;
  logic                     rvalid_q;
  logic                     rlast_q;
  logic [1:0]               rresp_q;
  logic                     mem_cs_q;

  logic                     err_d;
  logic [MEM_ADDR_BITS-1:0] addr_d;
  logic [3:0]               beat_d;
  logic                     unused_addr_bits;

  // Only 4-byte INCR bursts are served; anything else returns SLVERR beats without touching the SRAM.
  assign err_d  = (ARBURST_S != 2'b01) || (ARSIZE_S != 3'b010);
  assign addr_d = addr_q + MEM_ADDR_BITS'(1);
  assign beat_d = beat_q + 4'd1;

  assign unused_addr_bits = ^{ARADDR_S[31:MEM_ADDR_BITS+2], ARADDR_S[1:0]};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      mem_cs_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ARVALID_S && arready_q) begin
            id_q      <= ARID_S;
            len_q     <= ARLEN_S;
            addr_q    <= ARADDR_S[MEM_ADDR_BITS+1:2];
            err_q     <= err_d;
            beat_q    <= '0;
            arready_q <= 1'b0;
            mem_cs_q  <= ~err_d;
            state_q   <= FETCH;
          end
        end

        FETCH: begin
          // SRAM data is valid at the end of the select cycle, so it is captured on the way into RESP.
          mem_cs_q <= 1'b0;
          data_q   <= err_q ? 32'h0 : MEM_DO;
          rvalid_q <= 1'b1;
          rlast_q  <= (beat_q == len_q);
          rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
          state_q  <= RESP;
        end

        RESP: begin
          if (RREADY_S) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              beat_q   <= beat_d;
              addr_q   <= addr_d;
              mem_cs_q <= ~err_q;
              state_q  <= FETCH;
            end
          end
        end

        default: begin
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
          mem_cs_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ARREADY_S = arready_q;
  assign RVALID_S  = rvalid_q;
  assign RID_S     = id_q;
  assign RDATA_S   = data_q;
  assign RRESP_S   = rresp_q;
  assign RLAST_S   = rlast_q;
  assign MEM_CS    = mem_cs_q;
  assign MEM_OE    = mem_cs_q;
  assign MEM_A     = addr_q;

endmodule

// File: tb/tb_axi_slave_read_ctrl.sv
// Scoreboard bench for axi_slave_read_ctrl: directed AR bursts push expected R beats and
// SRAM addresses; a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_slave_read_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S;
  logic        MEM_CS;
  logic        MEM_OE;
  logic [13:0] MEM_A;
  logic [31:0] MEM_DO;

  axi_slave_read_ctrl #(.MEM_ADDR_BITS(14)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .MEM_CS(MEM_CS), .MEM_OE(MEM_OE), .MEM_A(MEM_A), .MEM_DO(MEM_DO)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0] mem [0:16383];
  assign MEM_DO = (MEM_CS && MEM_OE) ? mem[MEM_A] : 32'hBAD0_BAD0;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t rq[$];
  int    aq[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int hs       = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  int mon_beat  = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: SRAM accesses and accepted R beats are compared against the scoreboard.
  always @(negedge ACLK) begin
    if (ARESET === 1'b0) begin
      if (MEM_CS) begin
        chk("mem_oe_with_cs", {63'b0, MEM_OE}, 64'd1);
        if (aq.size() == 0) fail_now("unexpected MEM_CS pulse");
        else chk("mem_a", {50'b0, MEM_A}, 64'(aq.pop_front()));
      end else if (MEM_OE) begin
        fail_now("MEM_OE without MEM_CS");
      end
      if (RVALID_S && RREADY_S) begin
        if (rq.size() == 0) begin
          fail_now("unexpected R beat");
        end else begin
          beat_t e;
          e = rq.pop_front();
          chk("rid",   {56'b0, RID_S},   {56'b0, e.id});
          chk("rdata", {32'b0, RDATA_S}, {32'b0, e.data});
          chk("rresp", {62'b0, RRESP_S}, {62'b0, e.resp});
          chk("rlast", {63'b0, RLAST_S}, {63'b0, e.last});
          if (mon_beat == 0) first_cyc = cyc;
          if (e.last) begin
            last_cyc = cyc;
            mon_beat = 0;
          end else begin
            mon_beat++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] burst, input logic [2:0] size);
    logic  err;
    int    w;
    beat_t b;
    bit    got;
    err = (burst != 2'b01) || (size != 3'b010);
    for (int i = 0; i <= int'(len); i++) begin
      w      = (int'(addr[15:2]) + i) % 16384;
      b.id   = id;
      b.data = err ? 32'h0 : mem[w];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      rq.push_back(b);
      if (!err) aq.push_back(w);
    end
    tick();
    ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARBURST_S = burst; ARSIZE_S = size;
    ARVALID_S = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (ARREADY_S) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) fail_now("ARREADY timeout");
    tick();
    hs = cyc;
    ARVALID_S = 1'b0;
    chk("arready_low_in_fetch", {63'b0, ARREADY_S}, 64'd0);
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (rq.size() == 0 && ARREADY_S) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) fail_now("burst completion timeout");
    chk("addr_queue_empty", 64'(aq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [43:0] snap;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
    mem[4] = 32'hDEAD_BEEF;

    // Reset with a competing AR request: reset must win.
    ARESET = 1'b1; RREADY_S = 1'b1;
    ARID_S = 8'hFF; ARADDR_S = 32'hFFFF_FFFF; ARLEN_S = 4'hF;
    ARSIZE_S = 3'b010; ARBURST_S = 2'b01; ARVALID_S = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0; ARVALID_S = 1'b0;
    chk("rst_arready", {63'b0, ARREADY_S}, 64'd1);
    chk("rst_rvalid",  {63'b0, RVALID_S},  64'd0);
    chk("rst_rlast",   {63'b0, RLAST_S},   64'd0);
    chk("rst_rid",     {56'b0, RID_S},     64'd0);
    chk("rst_rdata",   {32'b0, RDATA_S},   64'd0);
    chk("rst_rresp",   {62'b0, RRESP_S},   64'd0);
    chk("rst_mem_cs",  {63'b0, MEM_CS},    64'd0);
    chk("rst_mem_oe",  {63'b0, MEM_OE},    64'd0);
    chk("rst_mem_a",   {50'b0, MEM_A},     64'd0);
    tick();
    chk("idle_after_rst", {63'b0, ARREADY_S}, 64'd1);

    // Single beat: word 4, RVALID in the second cycle after the handshake cycle.
    do_ar(8'h12, 32'h0000_0010, 4'd0, 2'b01, 3'b010);
    wait_done();
    chk("single_latency", 64'(first_cyc - hs), 64'd1);

    // Four-beat burst completing 8 cycles after the handshake.
    do_ar(8'h3A, 32'h0000_0100, 4'd3, 2'b01, 3'b010);
    wait_done();
    chk("burst4_first", 64'(first_cyc - hs), 64'd1);
    chk("burst4_done",  64'(last_cyc - hs),  64'd7);

    // Backpressure on the second beat for five cycles.
    do_ar(8'h55, 32'h0000_0200, 4'd3, 2'b01, 3'b010);
    tick();
    tick();
    RREADY_S = 1'b0;
    tick();
    snap = {RVALID_S, RID_S, RDATA_S, RRESP_S, RLAST_S};
    chk("bp_rvalid", {63'b0, RVALID_S}, 64'd1);
    chk("bp_rdata",  {32'b0, RDATA_S},  {32'b0, mem[129]});
    chk("bp_no_cs",  {63'b0, MEM_CS},   64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_stable", {20'b0, RVALID_S, RID_S, RDATA_S, RRESP_S, RLAST_S}, {20'b0, snap});
      chk("bp_no_cs",  {63'b0, MEM_CS}, 64'd0);
    end
    RREADY_S = 1'b1;
    wait_done();

    // Address wrap at the top of the SRAM, then ignored address bits.
    do_ar(8'h21, 32'h0000_FFFC, 4'd1, 2'b01, 3'b010);
    wait_done();
    do_ar(8'h22, 32'hFFF0_0013, 4'd0, 2'b01, 3'b010);
    wait_done();

    // Unsupported burst type and unsupported size: SLVERR beats, no SRAM access.
    do_ar(8'h77, 32'h0000_0040, 4'd2, 2'b10, 3'b010);
    wait_done();
    chk("err_burst_done", 64'(last_cyc - hs), 64'd5);
    do_ar(8'h78, 32'h0000_0040, 4'd0, 2'b01, 3'b000);
    wait_done();

    // Reset during the response of the first beat of an 8-beat burst.
    do_ar(8'hC1, 32'h0000_0300, 4'd7, 2'b01, 3'b010);
    tick();
    chk("pre_rst_rvalid", {63'b0, RVALID_S}, 64'd1);
    RREADY_S = 1'b0;
    ARESET   = 1'b1;
    tick();
    ARESET   = 1'b0;
    RREADY_S = 1'b1;
    rq.delete();
    aq.delete();
    chk("midrst_rvalid",  {63'b0, RVALID_S},  64'd0);
    chk("midrst_arready", {63'b0, ARREADY_S}, 64'd1);
    chk("midrst_rdata",   {32'b0, RDATA_S},   64'd0);
    chk("midrst_mem_cs",  {63'b0, MEM_CS},    64'd0);
    repeat (6) tick();
    chk("no_beats_after_rst", {63'b0, RVALID_S}, 64'd0);

    do_ar(8'h9C, 32'h0000_0040, 4'd1, 2'b01, 3'b010);
    wait_done();
    chk("rq_empty_end", 64'(rq.size()), 64'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
